mc_ctrl: RTL and testbench

Parametrised multi-cycle processor control FSM. Sequences each instruction through fetch, decode, execute, memory and writeback, and drives register-file, ALU, program-counter and memory control from the current opcode, addressing mode and status flags. Relative to the earlier controller it adds:

- a MEM_RDY wait-state handshake with timeout;
- a latched HALT state instead of a simulation stop;
- branch control;
- a retired-instruction counter.

It sits between the instruction register / status register and the datapath.

---
 rtl/mc_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_mc_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle processor control FSM: fetch/decode/execute/mem/writeback sequencing
// with memory wait-state timeout, latched halt, branch control and retired-instruction count.
module mc_ctrl #(
    parameter int OPW         = 4,
    parameter int ALUW        = 2,
    parameter int IMM_MODE    = 8,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNTW        = 16
) (
    input  logic            CLK,
    input  logic            RST_F,
    input  logic [OPW-1:0]  OPCODE,
    input  logic [3:0]      MM,
    input  logic [3:0]      STAT,
    input  logic            MEM_RDY,
    output logic            RF_WE,
    output logic [ALUW-1:0] ALU_OP,
    output logic            WB_SEL,
    output logic            RD_SEL,
    output logic            PC_WRITE,
    output logic            PC_SEL,
    output logic            PC_RST,
    output logic            BR_SEL,
    output logic            IR_LOAD,
    output logic            MEM_REQ,
    output logic            MEM_WE,
    output logic            HALTED,
    output logic            ERR,
    output logic [2:0]      STATE,
    output logic [CNTW-1:0] INSTR_CNT
);

    typedef enum logic [2:0] {
        S_START0    = 3'd0,
        S_START1    = 3'd1,
        S_FETCH     = 3'd2,
        S_DECODE    = 3'd3,
        S_EXECUTE   = 3'd4,
        S_MEM       = 3'd5,
        S_WRITEBACK = 3'd6,
        S_HALT      = 3'd7
    } state_t;

    localparam logic [OPW-1:0] OP_LOD = OPW'(1);
    localparam logic [OPW-1:0] OP_STR = OPW'(2);
    localparam logic [OPW-1:0] OP_BRA = OPW'(4);
    localparam logic [OPW-1:0] OP_BRR = OPW'(5);
    localparam logic [OPW-1:0] OP_BNE = OPW'(6);
    localparam logic [OPW-1:0] OP_ALU = OPW'(8);
    localparam logic [OPW-1:0] OP_HLT = OPW'(15);
    localparam logic [3:0]     IMM_MM = 4'(IMM_MODE);

    // Wide enough to hold MEM_TIMEOUT itself, so the increment never overflows.
    localparam int WAITW = $clog2(MEM_TIMEOUT + 1);

    state_t          state_q, state_d;
    logic [WAITW-1:0] wait_q, wait_d;
    logic [WAITW-1:0] wait_inc;
    logic            err_q, err_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic is_lod, is_str, is_mem_op, is_alu, is_imm;

    assign is_lod    = (OPCODE == OP_LOD);
    assign is_str    = (OPCODE == OP_STR);
    assign is_mem_op = is_lod | is_str;
    assign is_alu    = (OPCODE == OP_ALU);
    assign is_imm    = (MM == IMM_MM);
    assign wait_inc  = wait_q + 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or negedge RST_F) begin
        if (!RST_F) begin
            state_q <= S_START0;
            wait_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        RF_WE    = 1'b0;
        ALU_OP   = '0;
        WB_SEL   = 1'b0;
        RD_SEL   = 1'b0;
        PC_WRITE = 1'b0;
        PC_SEL   = 1'b0;
        PC_RST   = 1'b0;
        BR_SEL   = 1'b0;
        IR_LOAD  = 1'b0;
        MEM_REQ  = 1'b0;
        MEM_WE   = 1'b0;
        HALTED   = 1'b0;

        case (state_q)
            S_START0: begin
                PC_RST  = 1'b1;
                state_d = S_START1;
            end
            S_START1: begin
                PC_RST  = 1'b1;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                IR_LOAD  = 1'b1;
                PC_WRITE = 1'b1;
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                state_d = (OPCODE == OP_HLT) ? S_HALT : S_EXECUTE;
            end
            S_EXECUTE: begin
                if (is_alu && is_imm) begin
                    ALU_OP = ALUW'(1);
                end
                wait_d  = '0;
                state_d = S_MEM;
            end
            S_MEM: begin
                if (is_mem_op) begin
                    MEM_REQ = 1'b1;
                    MEM_WE  = is_str;
                    // A ready on the cycle that would time out still wins.
                    if (MEM_RDY) begin
                        state_d = S_WRITEBACK;
                    end else if (wait_inc == WAITW'(MEM_TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        wait_d = wait_inc;
                    end
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                case (OPCODE)
                    OP_ALU: begin
                        RF_WE  = 1'b1;
                        RD_SEL = !is_imm;
                    end
                    OP_LOD: begin
                        RF_WE  = 1'b1;
                        WB_SEL = 1'b1;
                        RD_SEL = 1'b1;
                    end
                    OP_BRA: begin
                        PC_WRITE = 1'b1;
                        PC_SEL   = 1'b1;
                    end
                    OP_BRR: begin
                        PC_WRITE = 1'b1;
                        PC_SEL   = 1'b1;
                        BR_SEL   = 1'b1;
                    end
                    OP_BNE: begin
                        if ((STAT & MM) != 4'd0) begin
                            PC_WRITE = 1'b1;
                            PC_SEL   = 1'b1;
                            BR_SEL   = 1'b1;
                        end
                    end
                    default: ;
                endcase
                cnt_d   = cnt_q + 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                HALTED = 1'b1;
            end
            default: state_d = S_START0;
        endcase
    end

    assign ERR       = err_q;
    assign STATE     = state_q;
    assign INSTR_CNT = cnt_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: a per-instruction reference model pushes the
// expected output vector of every cycle; a negedge monitor pops and compares.
module tb_mc_ctrl;
    localparam int OPW = 4, ALUW = 2, IMM_MODE = 8, TMO = 4, CNTW = 4;
    localparam logic [2:0] ST_S0 = 3'd0, ST_S1 = 3'd1, ST_F = 3'd2, ST_D = 3'd3,
                           ST_E = 3'd4, ST_M = 3'd5, ST_W = 3'd6, ST_H = 3'd7;

    logic            CLK = 1'b0;
    logic            RST_F = 1'b0;
    logic [OPW-1:0]  OPCODE = '0;
    logic [3:0]      MM = '0, STAT = '0;
    logic            MEM_RDY = 1'b0;
    logic            RF_WE, WB_SEL, RD_SEL, PC_WRITE, PC_SEL, PC_RST, BR_SEL;
    logic            IR_LOAD, MEM_REQ, MEM_WE, HALTED, ERR;
    logic [ALUW-1:0] ALU_OP;
    logic [2:0]      STATE;
    logic [CNTW-1:0] INSTR_CNT;

    mc_ctrl #(.OPW(OPW), .ALUW(ALUW), .IMM_MODE(IMM_MODE), .MEM_TIMEOUT(TMO), .CNTW(CNTW)) dut (
        .CLK(CLK), .RST_F(RST_F), .OPCODE(OPCODE), .MM(MM), .STAT(STAT), .MEM_RDY(MEM_RDY),
        .RF_WE(RF_WE), .ALU_OP(ALU_OP), .WB_SEL(WB_SEL), .RD_SEL(RD_SEL),
        .PC_WRITE(PC_WRITE), .PC_SEL(PC_SEL), .PC_RST(PC_RST), .BR_SEL(BR_SEL),
        .IR_LOAD(IR_LOAD), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .HALTED(HALTED),
        .ERR(ERR), .STATE(STATE), .INSTR_CNT(INSTR_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [2:0]      st;
        logic [ALUW-1:0] alu_op;
        logic rf_we, wb_sel, rd_sel, pc_write, pc_sel, pc_rst, br_sel;
        logic ir_load, mem_req, mem_we, halted, err;
        logic [CNTW-1:0] cnt;
    } obs_t;

    obs_t sb[$];
    obs_t cur;
    int   errors = 0;
    int   checks = 0;
    int   cycle_no = 0;
    int   model_cnt = 0;
    bit   model_err = 1'b0;

    always_comb begin
        cur = '{st: STATE, alu_op: ALU_OP, rf_we: RF_WE, wb_sel: WB_SEL, rd_sel: RD_SEL,
                pc_write: PC_WRITE, pc_sel: PC_SEL, pc_rst: PC_RST, br_sel: BR_SEL,
                ir_load: IR_LOAD, mem_req: MEM_REQ, mem_we: MEM_WE, halted: HALTED,
                err: ERR, cnt: INSTR_CNT};
    end

    task automatic check(input string name, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    initial begin : monitor
        obs_t e;
        forever begin
            @(negedge CLK);
            cycle_no++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check($sformatf("cyc%0d_state%0d", cycle_no, e.st), cur, e);
            end
        end
    end

    // Expected vector for a state with all control outputs at 0.
    function automatic obs_t idle(input logic [2:0] st);
        obs_t o;
        o     = '0;
        o.st  = st;
        o.err = model_err;
        o.cnt = CNTW'(model_cnt);
        return o;
    endfunction

    task automatic slot(input obs_t e);
        sb.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic rand_rdy();
        MEM_RDY = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        obs_t e;
        RST_F     = 1'b0;
        rand_rdy();
        model_cnt = 0;
        model_err = 1'b0;
        e = idle(ST_S0); e.pc_rst = 1'b1;
        slot(e);
        slot(e);
        RST_F = 1'b1;
        slot(e);
        e = idle(ST_S1); e.pc_rst = 1'b1;
        slot(e);
    endtask

    // One instruction from FETCH onward. need_reset reports a HALT was entered.
    task automatic run(input logic [3:0] op, input logic [3:0] mm, input logic [3:0] stat,
                       input int delay, input int rst_at, output bit need_reset);
        obs_t e;
        bit   is_mem, tmo;
        int   nmem;
        need_reset = 1'b0;
        OPCODE = op; MM = mm; STAT = stat;
        rand_rdy();
        e = idle(ST_F); e.ir_load = 1'b1; e.pc_write = 1'b1;
        slot(e);
        rand_rdy();
        slot(idle(ST_D));
        if (op == 4'd15) begin
            repeat (3) begin
                rand_rdy();
                e = idle(ST_H); e.halted = 1'b1;
                slot(e);
            end
            need_reset = 1'b1;
            return;
        end
        rand_rdy();
        e = idle(ST_E);
        if (op == 4'd8) e.alu_op = (mm == 4'(IMM_MODE)) ? 2'd1 : 2'd0;
        slot(e);
        is_mem = (op == 4'd1) || (op == 4'd2);
        tmo    = is_mem && (delay >= TMO);
        nmem   = !is_mem ? 1 : (tmo ? TMO : delay + 1);
        for (int i = 0; i < nmem; i++) begin
            if (i == rst_at) begin
                do_reset();
                return;
            end
            if (is_mem) MEM_RDY = (i == delay);
            else        rand_rdy();
            e = idle(ST_M); e.mem_req = is_mem; e.mem_we = (op == 4'd2);
            slot(e);
        end
        if (tmo) begin
            model_err = 1'b1;
            repeat (3) begin
                rand_rdy();
                e = idle(ST_H); e.halted = 1'b1;
                slot(e);
            end
            need_reset = 1'b1;
            return;
        end
        rand_rdy();
        e = idle(ST_W);
        case (op)
            4'd8: begin e.rf_we = 1'b1; e.rd_sel = (mm != 4'(IMM_MODE)); end
            4'd1: begin e.rf_we = 1'b1; e.wb_sel = 1'b1; e.rd_sel = 1'b1; end
            4'd4: begin e.pc_write = 1'b1; e.pc_sel = 1'b1; end
            4'd5: begin e.pc_write = 1'b1; e.pc_sel = 1'b1; e.br_sel = 1'b1; end
            4'd6: if ((stat & mm) != 4'd0) begin
                      e.pc_write = 1'b1; e.pc_sel = 1'b1; e.br_sel = 1'b1;
                  end
            default: ;
        endcase
        slot(e);
        model_cnt = (model_cnt + 1) % (1 << CNTW);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, limit 500000", $time);
        $fatal(1, "timeout");
    end

    initial begin : driver
        bit hr;
        logic [3:0] op, mm;
        logic [3:0] wrap_ops [5];
        wrap_ops = '{4'd0, 4'd8, 4'd4, 4'd5, 4'd6};
        @(posedge CLK);
        #1;
        do_reset();
        repeat (3) run(4'd0, 4'd0, 4'd0, 0, -1, hr);
        run(4'd8, 4'd8, 4'd0, 0, -1, hr);
        run(4'd8, 4'd0, 4'd0, 0, -1, hr);
        run(4'd1, 4'd3, 4'd0, 3, -1, hr);
        run(4'd2, 4'd3, 4'd0, 0, -1, hr);
        run(4'd6, 4'b0010, 4'b0010, 0, -1, hr);
        run(4'd6, 4'b0100, 4'b0010, 0, -1, hr);
        run(4'd4, 4'd0, 4'd0, 0, -1, hr);
        run(4'd5, 4'd0, 4'd0, 0, -1, hr);
        run(4'd1, 4'd0, 4'd0, TMO, -1, hr);
        if (hr) do_reset();
        run(4'd1, 4'd0, 4'd0, TMO - 1, -1, hr);
        run(4'd15, 4'd0, 4'd0, 0, -1, hr);
        if (hr) do_reset();
        run(4'd0, 4'd0, 4'd0, 0, -1, hr);
        run(4'd1, 4'd0, 4'd0, 3, 1, hr);
        // Enough non-halting instructions to wrap the narrow counter.
        for (int k = 0; k < 20; k++) begin
            run(wrap_ops[$urandom_range(0, 4)], 4'($urandom), 4'($urandom), 0, -1, hr);
        end
        for (int k = 0; k < 60; k++) begin
            op = 4'($urandom_range(0, 14));
            if ($urandom_range(0, 19) == 0) op = 4'd15;
            mm = ($urandom_range(0, 2) == 0) ? 4'(IMM_MODE) : 4'($urandom);
            run(op, mm, 4'($urandom), $urandom_range(0, TMO), -1, hr);
            if (hr) do_reset();
        end
        repeat (2) @(negedge CLK);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
